// File: rtl/multiport_reg_file.sv
// Register file with two bypassed combinational read ports, two prioritised write ports
// and a per-register pending-write scoreboard for decode stalls.
module multiport_reg_file #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_SIZE = 4,
    parameter int MEM_SIZE  = 16,
    parameter int ZERO_REG  = 0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [ADDR_SIZE-1:0] RADDR1,
    input  logic [ADDR_SIZE-1:0] RADDR2,
    output logic [WORD_SIZE-1:0] DATA_OUT1,
    output logic [WORD_SIZE-1:0] DATA_OUT2,
    output logic                 BUSY1,
    output logic                 BUSY2,
    input  logic                 W_ON_A,
    input  logic                 W_ON_B,
    input  logic [ADDR_SIZE-1:0] WADDR_A,
    input  logic [ADDR_SIZE-1:0] WADDR_B,
    input  logic [WORD_SIZE-1:0] DATA_IN_A,
    input  logic [WORD_SIZE-1:0] DATA_IN_B,
    input  logic                 BUSY_SET,
    input  logic [ADDR_SIZE-1:0] BUSY_ADDR
);

    logic [WORD_SIZE-1:0] mem [MEM_SIZE];
    logic [MEM_SIZE-1:0]  busy;
    logic [MEM_SIZE-1:0]  busy_nxt;
    logic                 wr_a;
    logic                 wr_b;
    logic                 set_ok;

    // An address is usable when it names a real register that is not the hardwired zero.
    function automatic logic addr_ok(input logic [ADDR_SIZE-1:0] a);
        return (32'(a) < MEM_SIZE) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    function automatic logic [WORD_SIZE-1:0] reset_val(input int idx);
        logic [31:0] v;
        case (idx)
            0:       v = (ZERO_REG != 0) ? 32'h0 : 32'h1111;
            1:       v = 32'h2222;
            2:       v = 32'h4444;
            3:       v = 32'h8888;
            default: v = 32'h0;
        endcase
        return WORD_SIZE'(v);
    endfunction

    assign wr_a   = W_ON_A && addr_ok(WADDR_A);
    assign wr_b   = W_ON_B && addr_ok(WADDR_B);
    assign set_ok = BUSY_SET && addr_ok(BUSY_ADDR);

    // A set for a new producer overrides the clear from the retiring one.
    always_comb begin
        busy_nxt = busy;
        for (int i = 0; i < MEM_SIZE; i++) begin
            if ((wr_a && (WADDR_A == ADDR_SIZE'(i))) || (wr_b && (WADDR_B == ADDR_SIZE'(i))))
                busy_nxt[i] = 1'b0;
            if (set_ok && (BUSY_ADDR == ADDR_SIZE'(i)))
                busy_nxt[i] = 1'b1;
        end
    end

    // Port B is written last so it wins a same-address collision.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < MEM_SIZE; i++)
                mem[i] <= reset_val(i);
            busy <= '0;
        end else begin
            if (wr_a)
                mem[WADDR_A] <= DATA_IN_A;
            if (wr_b)
                mem[WADDR_B] <= DATA_IN_B;
            busy <= busy_nxt;
        end
    end

    logic [1:0][ADDR_SIZE-1:0] rd_addr;
    assign rd_addr = {RADDR2, RADDR1};

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic                 in_rng;
        logic                 hit_a;
        logic                 hit_b;
        logic [WORD_SIZE-1:0] data;
        logic                 bsy;

        assign in_rng = addr_ok(rd_addr[p]);
        assign hit_a  = W_ON_A && (WADDR_A == rd_addr[p]);
        assign hit_b  = W_ON_B && (WADDR_B == rd_addr[p]);

        // Data being written this cycle is already valid, so it both bypasses and unblocks.
        always_comb begin
            data = '0;
            bsy  = 1'b0;
            if (in_rng) begin
                if (hit_b)
                    data = DATA_IN_B;
                else if (hit_a)
                    data = DATA_IN_A;
                else
                    data = mem[rd_addr[p]];
                bsy = busy[rd_addr[p]] && !(hit_a || hit_b);
            end
        end
    end

    assign DATA_OUT1 = g_rd[0].data;
    assign DATA_OUT2 = g_rd[1].data;
    assign BUSY1     = g_rd[0].bsy;
    assign BUSY2     = g_rd[1].bsy;

endmodule

// File: tb/tb_multiport_reg_file.sv
// Bench for multiport_reg_file: a default instance and a ZERO_REG=1, 12-register instance
// share stimulus; directed table, corner sequences and random traffic vs a reference model.
module tb_multiport_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  raddr1, raddr2, waddr_a, waddr_b, busy_addr;
    logic        w_on_a, w_on_b, busy_set;
    logic [15:0] din_a, din_b;
    logic [15:0] d0_1, d0_2, d1_1, d1_2;
    logic        b0_1, b0_2, b1_1, b1_2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multiport_reg_file #(.WORD_SIZE(16), .ADDR_SIZE(4), .MEM_SIZE(16), .ZERO_REG(0)) dut0 (
        .CLK(clk), .RST(rst), .RADDR1(raddr1), .RADDR2(raddr2),
        .DATA_OUT1(d0_1), .DATA_OUT2(d0_2), .BUSY1(b0_1), .BUSY2(b0_2),
        .W_ON_A(w_on_a), .W_ON_B(w_on_b), .WADDR_A(waddr_a), .WADDR_B(waddr_b),
        .DATA_IN_A(din_a), .DATA_IN_B(din_b), .BUSY_SET(busy_set), .BUSY_ADDR(busy_addr)
    );

    multiport_reg_file #(.WORD_SIZE(16), .ADDR_SIZE(4), .MEM_SIZE(12), .ZERO_REG(1)) dut1 (
        .CLK(clk), .RST(rst), .RADDR1(raddr1), .RADDR2(raddr2),
        .DATA_OUT1(d1_1), .DATA_OUT2(d1_2), .BUSY1(b1_1), .BUSY2(b1_2),
        .W_ON_A(w_on_a), .W_ON_B(w_on_b), .WADDR_A(waddr_a), .WADDR_B(waddr_b),
        .DATA_IN_A(din_a), .DATA_IN_B(din_b), .BUSY_SET(busy_set), .BUSY_ADDR(busy_addr)
    );

    // Reference model: index 0 = default instance, 1 = zero-register / 12-entry instance.
    logic [15:0] mm [2][16];
    bit          mb [2][16];
    int          msize [2] = '{16, 12};
    int          zr    [2] = '{0, 1};

    function automatic bit m_ok(int z, logic [3:0] a);
        return (int'(a) < msize[z]) && !(zr[z] == 1 && a == 4'd0);
    endfunction

    function automatic logic [15:0] m_read(int z, logic [3:0] ra);
        if (!m_ok(z, ra)) return 16'h0;
        if (w_on_b && waddr_b == ra) return din_b;
        if (w_on_a && waddr_a == ra) return din_a;
        return mm[z][ra];
    endfunction

    function automatic bit m_busy(int z, logic [3:0] ra);
        if (!m_ok(z, ra)) return 1'b0;
        if ((w_on_a && waddr_a == ra) || (w_on_b && waddr_b == ra)) return 1'b0;
        return mb[z][ra];
    endfunction

    task automatic model_reset();
        logic [15:0] rv [4] = '{16'h1111, 16'h2222, 16'h4444, 16'h8888};
        for (int z = 0; z < 2; z++)
            for (int r = 0; r < 16; r++) begin
                mm[z][r] = (r < 4) ? rv[r] : 16'h0;
                mb[z][r] = 1'b0;
            end
        mm[1][0] = 16'h0;
    endtask

    task automatic model_update();
        for (int z = 0; z < 2; z++) begin
            if (w_on_a && m_ok(z, waddr_a)) begin
                mm[z][waddr_a] = din_a;
                mb[z][waddr_a] = 1'b0;
            end
            if (w_on_b && m_ok(z, waddr_b)) begin
                mm[z][waddr_b] = din_b;
                mb[z][waddr_b] = 1'b0;
            end
            if (busy_set && m_ok(z, busy_addr))
                mb[z][busy_addr] = 1'b1;
        end
    endtask

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(string tag);
        check({tag, " dut0.d1"}, d0_1, m_read(0, raddr1));
        check({tag, " dut0.d2"}, d0_2, m_read(0, raddr2));
        check({tag, " dut0.b1"}, 16'(b0_1), 16'(m_busy(0, raddr1)));
        check({tag, " dut0.b2"}, 16'(b0_2), 16'(m_busy(0, raddr2)));
        check({tag, " dut1.d1"}, d1_1, m_read(1, raddr1));
        check({tag, " dut1.d2"}, d1_2, m_read(1, raddr2));
        check({tag, " dut1.b1"}, 16'(b1_1), 16'(m_busy(1, raddr1)));
        check({tag, " dut1.b2"}, 16'(b1_2), 16'(m_busy(1, raddr2)));
    endtask

    // Commit the current inputs at the next rising edge and return at the falling edge.
    task automatic tick();
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(logic [3:0] r1, logic [3:0] r2);
        w_on_a = 1'b0; w_on_b = 1'b0; busy_set = 1'b0;
        raddr1 = r1; raddr2 = r2;
    endtask

    typedef struct {
        bit          wa; logic [3:0] aa; logic [15:0] da;
        bit          wb; logic [3:0] ab; logic [15:0] db;
        bit          bs; logic [3:0] ba;
        logic [3:0]  r1; logic [3:0] r2;
        logic [15:0] e1; logic [15:0] e2;
        bit          eb1; bit eb2;
    } vec_t;

    vec_t tbl [18];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl = '{
            '{1'b0,4'd0,16'h0,    1'b0,4'd0,16'h0,    1'b0,4'd0, 4'd0,4'd1,   16'h1111,16'h2222,1'b0,1'b0},
            '{1'b0,4'd0,16'h0,    1'b0,4'd0,16'h0,    1'b0,4'd0, 4'd2,4'd3,   16'h4444,16'h8888,1'b0,1'b0},
            '{1'b0,4'd0,16'h0,    1'b0,4'd0,16'h0,    1'b0,4'd0, 4'd15,4'd4,  16'h0000,16'h0000,1'b0,1'b0},
            '{1'b1,4'd5,16'hAAAA, 1'b1,4'd5,16'hBBBB, 1'b0,4'd0, 4'd5,4'd5,   16'hBBBB,16'hBBBB,1'b0,1'b0},
            '{1'b0,4'd0,16'h0,    1'b0,4'd0,16'h0,    1'b0,4'd0, 4'd5,4'd5,   16'hBBBB,16'hBBBB,1'b0,1'b0},
            '{1'b1,4'd7,16'h1234, 1'b0,4'd0,16'h0,    1'b0,4'd0, 4'd7,4'd7,   16'h1234,16'h1234,1'b0,1'b0},
            '{1'b1,4'd7,16'h5678, 1'b0,4'd0,16'h0,    1'b0,4'd0, 4'd7,4'd7,   16'h5678,16'h5678,1'b0,1'b0},
            '{1'b0,4'd0,16'h0,    1'b0,4'd0,16'h0,    1'b0,4'd0, 4'd7,4'd7,   16'h5678,16'h5678,1'b0,1'b0},
            '{1'b0,4'd0,16'h0,    1'b0,4'd0,16'h0,    1'b1,4'd9, 4'd9,4'd8,   16'h0000,16'h0000,1'b0,1'b0},
            '{1'b0,4'd0,16'h0,    1'b0,4'd0,16'h0,    1'b0,4'd0, 4'd9,4'd8,   16'h0000,16'h0000,1'b1,1'b0},
            '{1'b0,4'd0,16'h0,    1'b1,4'd9,16'h0F0F, 1'b0,4'd0, 4'd9,4'd9,   16'h0F0F,16'h0F0F,1'b0,1'b0},
            '{1'b0,4'd0,16'h0,    1'b0,4'd0,16'h0,    1'b0,4'd0, 4'd9,4'd9,   16'h0F0F,16'h0F0F,1'b0,1'b0},
            '{1'b1,4'd9,16'h1357, 1'b0,4'd0,16'h0,    1'b1,4'd9, 4'd9,4'd9,   16'h1357,16'h1357,1'b0,1'b0},
            '{1'b0,4'd0,16'h0,    1'b0,4'd0,16'h0,    1'b0,4'd0, 4'd9,4'd9,   16'h1357,16'h1357,1'b1,1'b1},
            '{1'b1,4'd10,16'hAAAA,1'b1,4'd11,16'hBBBB,1'b0,4'd0, 4'd10,4'd11, 16'hAAAA,16'hBBBB,1'b0,1'b0},
            '{1'b0,4'd0,16'h0,    1'b0,4'd0,16'h0,    1'b0,4'd0, 4'd10,4'd11, 16'hAAAA,16'hBBBB,1'b0,1'b0},
            '{1'b1,4'd3,16'h3333, 1'b0,4'd0,16'h0,    1'b1,4'd2, 4'd2,4'd3,   16'h4444,16'h3333,1'b0,1'b0},
            '{1'b0,4'd0,16'h0,    1'b0,4'd0,16'h0,    1'b0,4'd0, 4'd2,4'd3,   16'h4444,16'h3333,1'b1,1'b0}
        };

        rst = 1'b1;
        din_a = 16'h0; din_b = 16'h0; waddr_a = 4'd0; waddr_b = 4'd0; busy_addr = 4'd0;
        idle(4'd0, 4'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Directed table against hand-derived values for the default instance.
        for (int i = 0; i < 18; i++) begin
            w_on_a = tbl[i].wa; waddr_a = tbl[i].aa; din_a = tbl[i].da;
            w_on_b = tbl[i].wb; waddr_b = tbl[i].ab; din_b = tbl[i].db;
            busy_set = tbl[i].bs; busy_addr = tbl[i].ba;
            raddr1 = tbl[i].r1; raddr2 = tbl[i].r2;
            #1;
            check($sformatf("tbl%0d d1", i), d0_1, tbl[i].e1);
            check($sformatf("tbl%0d d2", i), d0_2, tbl[i].e2);
            check($sformatf("tbl%0d b1", i), 16'(b0_1), 16'(tbl[i].eb1));
            check($sformatf("tbl%0d b2", i), 16'(b0_2), 16'(tbl[i].eb2));
            check_model($sformatf("tbl%0d", i));
            tick();
        end

        // Register 0 write and busy set: ignored on the zero-register instance only.
        idle(4'd0, 4'd0);
        w_on_a = 1'b1; waddr_a = 4'd0; din_a = 16'hFFFF;
        busy_set = 1'b1; busy_addr = 4'd0;
        #1;
        check("zr same d1", d1_1, 16'h0000);
        check("zr same b1", 16'(b1_1), 16'h0);
        check("r0 bypass d1", d0_1, 16'hFFFF);
        check("r0 bypass b1", 16'(b0_1), 16'h0);
        tick();
        idle(4'd0, 4'd0);
        #1;
        check("zr next d1", d1_1, 16'h0000);
        check("zr next b1", 16'(b1_1), 16'h0);
        check("r0 stored d1", d0_1, 16'hFFFF);
        check("r0 set wins b1", 16'(b0_1), 16'h1);
        check_model("zr");
        tick();

        // Asynchronous reset pulsed between edges after a committed write and set.
        idle(4'd4, 4'd0);
        w_on_a = 1'b1; waddr_a = 4'd4; din_a = 16'hCAFE;
        busy_set = 1'b1; busy_addr = 4'd4;
        #1;
        tick();
        idle(4'd4, 4'd0);
        #1;
        check("pre-rst d1", d0_1, 16'hCAFE);
        check("pre-rst b1", 16'(b0_1), 16'h1);
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        model_reset();
        #1;
        check("async rst d1", d0_1, 16'h0000);
        check("async rst b1", 16'(b0_1), 16'h0);
        check("async rst r0", d0_2, 16'h1111);
        check_model("arst");
        tick();

        // Writes and sets on an edge while reset is held are discarded.
        rst = 1'b1;
        idle(4'd4, 4'd1);
        w_on_b = 1'b1; waddr_b = 4'd1; din_b = 16'hBEEF;
        busy_set = 1'b1; busy_addr = 4'd4;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle(4'd4, 4'd1);
        #1;
        check("held rst b1", 16'(b0_1), 16'h0);
        check("held rst r1", d0_2, 16'h2222);
        tick();

        // Random traffic, with occasional mid-cycle reset pulses.
        for (int c = 0; c < 600; c++) begin
            w_on_a    = 1'($urandom_range(0, 1));
            w_on_b    = 1'($urandom_range(0, 1));
            waddr_a   = 4'($urandom_range(0, 15));
            waddr_b   = ($urandom_range(0, 3) == 0) ? waddr_a : 4'($urandom_range(0, 15));
            din_a     = 16'($urandom);
            din_b     = 16'($urandom);
            busy_set  = 1'($urandom_range(0, 1));
            busy_addr = 4'($urandom_range(0, 15));
            raddr1    = ($urandom_range(0, 3) == 0) ? waddr_b : 4'($urandom_range(0, 15));
            raddr2    = ($urandom_range(0, 3) == 0) ? waddr_a : 4'($urandom_range(0, 15));
            #1;
            check_model($sformatf("rnd%0d", c));
            if ($urandom_range(0, 63) == 0) begin
                #1 rst = 1'b1;
                #1 rst = 1'b0;
                model_reset();
                #1;
                check_model($sformatf("rnd%0d rst", c));
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multiport_reg_file.md
# multiport_reg_file

Parametrised register file for the pipelined CPU datapath, replacing the fixed 16x16 two-read/one-write file. It provides two combinational read ports and two rising-edge write ports with fixed priority, plus same-cycle write-to-read bypass. It also keeps a per-register pending-write scoreboard, so decode can stall on registers whose producer has not yet written back. It sits between decode (reads, scoreboard set) and write-back (writes).

## Interface
- WORD_SIZE, 16, data width of each register
- ADDR_SIZE, 4, register address width
- MEM_SIZE, 16, number of registers (MEM_SIZE <= 2**ADDR_SIZE)
- ZERO_REG, 0, when 1 register 0 reads as zero, ignores writes and is never busy

- CLK  input  1  clock; all state updates on rising edge
- RST  input  1  reset, asynchronous, active-high
- RADDR1, RADDR2  input  ADDR_SIZE  read addresses
- DATA_OUT1, DATA_OUT2  output  WORD_SIZE  read data (combinational, bypassed)
- BUSY1, BUSY2  output  1  pending-write flag for RADDR1 / RADDR2
- W_ON_A, W_ON_B  input  1  write enables, port A / port B
- WADDR_A, WADDR_B  input  ADDR_SIZE  write addresses
- DATA_IN_A, DATA_IN_B  input  WORD_SIZE  write data
- BUSY_SET  input  1  mark BUSY_ADDR as pending
- BUSY_ADDR  input  ADDR_SIZE  register whose write is now in flight

## Operation
- Reset values:
  - reg0=0x1111, reg1=0x2222, reg2=0x4444, reg3=0x8888, all others 0.
  - With ZERO_REG=1, reg0 resets to 0.
  - Values are zero-extended or truncated to WORD_SIZE.
  - All busy bits are cleared.
- Write:
  - On a rising edge with W_ON_x=1 and WADDR_x < MEM_SIZE, mem[WADDR_x] <= DATA_IN_x.
  - If both ports write the same address, port B wins.
  - Out-of-range addresses are ignored. Writes to reg0 are ignored when ZERO_REG=1.
- Read:
  - DATA_OUTn = mem[RADDRn], with bypass: a same-cycle enabled write to RADDRn drives DATA_IN onto DATA_OUTn.
  - Bypass priority is B, then A, then stored value.
  - An out-of-range RADDRn reads 0.
  - ZERO_REG=1 with RADDRn=0 reads 0, with no bypass.
- Scoreboard, per register, evaluated at the rising edge:
  - A busy bit clears when either write port writes that register.
  - A busy bit sets when BUSY_SET=1 and BUSY_ADDR selects it.
  - If set and clear hit the same register in the same cycle, set wins (the new producer is pending).
  - Out-of-range BUSY_ADDR is ignored. ZERO_REG=1 with BUSY_ADDR=0 is ignored.
- BUSYn = busy[RADDRn] AND NOT (same-cycle enabled write to RADDRn).
  - This matches the bypass: the data being written is valid now.
  - BUSYn is 0 for out-of-range RADDRn, and for RADDRn=0 when ZERO_REG=1.

## Timing
- Read latency is 0 cycles (combinational from RADDR, W_ON, WADDR and DATA_IN).
- Write latency is 1 edge. The stored value is visible with no bypass from the cycle after the edge.
- Busy set latency is 1 edge: BUSYn rises in the cycle after BUSY_SET.
- Busy clear is visible combinationally in the write cycle and is registered at the edge.
- RST asserted at any time, including mid-write: state returns to reset values immediately. Writes and sets on edges while RST=1 are discarded.
- On RST deassertion, the first rising edge behaves normally.

## Test plan
- Reset check: assert RST, deassert; read r0..r3 and r15 -> 0x1111, 0x2222, 0x4444, 0x8888, 0x0000. All BUSY=0.
- Dual-write collision: W_ON_A=W_ON_B=1, WADDR=5, DATA_IN_A=0xAAAA, DATA_IN_B=0xBBBB.
  - RADDR1=5 the same cycle -> 0xBBBB (bypass).
  - Next cycle with writes off -> 0xBBBB.
- Bypass vs stored: r7 holds 0x1234; write A r7=0x5678. RADDR1=RADDR2=7 -> both 0x5678 that cycle, 0x5678 after.
- Scoreboard:
  - BUSY_SET r9 -> BUSY1=1 (RADDR1=9) next cycle.
  - Write B r9=0x0F0F -> BUSY1=0 and DATA_OUT1=0x0F0F in the same cycle; BUSY1 stays 0 afterwards.
  - BUSY_SET r9 together with a write to r9 -> BUSY1=1 next cycle.
- ZERO_REG=1: write r0=0xFFFF and BUSY_SET r0 -> DATA_OUT1=0, BUSY1=0 in that cycle and the next.
- Async reset mid-operation: write r4=0xCAFE with BUSY_SET r4, and pulse RST between edges. Next read r4 -> 0x0000 and BUSY=0.
